// File: rtl/hid_pkg.sv
// Shared constants for the HID microcontroller bridge: command codes, key usages
// and the decoded key-event layout.
package hid_pkg;

  localparam logic [7:0] CMD_STATUS = 8'h00;
  localparam logic [7:0] CMD_KBD    = 8'h01;
  localparam logic [7:0] CMD_MOUSE  = 8'h02;
  localparam logic [7:0] CMD_JOY    = 8'h03;
  localparam logic [7:0] CMD_DB9    = 8'h04;

  localparam logic [6:0] FKEY_BASE = 7'h3A;

  // Numpad bit i is driven by the usage code at position i.
  localparam logic [6:0] NUMPAD_USAGE [0:7] = '{
    7'h5E, 7'h5C, 7'h5A, 7'h60, 7'h62, 7'h63, 7'h44, 7'h4B
  };

  typedef struct packed {
    logic       is_release;
    logic [6:0] usage;
  } key_evt_t;

  function automatic logic [7:0] numpad_onehot(input logic [6:0] usage);
    logic [7:0] hit;
    hit = '0;
    for (int i = 0; i < 8; i++) begin
      if (usage == NUMPAD_USAGE[i]) hit[i] = 1'b1;
    end
    return hit;
  endfunction

endpackage

// File: rtl/hid_mc_if.sv
// Byte stream between the MCU and the HID bridge.
interface hid_mc_if;
  // Handshake: a byte is taken on every clk edge where data_in_strobe is high;
  // there is no back-pressure. data_in_start marks the command byte of a frame.
  // data_out holds the reply to the most recent byte until the next one.
  logic       data_in_strobe;
  logic       data_in_start;
  logic [7:0] data_in;
  logic [7:0] data_out;

  modport master (output data_in_strobe, output data_in_start, output data_in,
                  input data_out);
  modport slave  (input data_in_strobe, input data_in_start, input data_in,
                  output data_out);
endinterface

// File: rtl/hid_mouse_axis.sv
// One signed mouse accumulator: saturating add of a signed byte plus a slow
// decay of one step toward zero.
module hid_mouse_axis #(
  parameter int W = 8
) (
  input  logic                clk,
  input  logic                reset_n,
  input  logic                add_en,
  input  logic [7:0]          add_val,
  input  logic                decay_en,
  output logic signed [W-1:0] acc
);

  localparam logic signed [W:0]   SUM_MAX = {2'b00, {(W-1){1'b1}}};
  localparam logic signed [W:0]   SUM_MIN = {2'b11, {(W-1){1'b0}}};
  localparam logic signed [W-1:0] ACC_MAX = {1'b0, {(W-1){1'b1}}};
  localparam logic signed [W-1:0] ACC_MIN = {1'b1, {(W-1){1'b0}}};
  localparam logic signed [W-1:0] ONE     = {{(W-1){1'b0}}, 1'b1};

  // One guard bit is enough: |add| <= 128 and |acc| <= 2^(W-1).
  logic signed [W:0] sum;

  always_comb begin
    sum = {acc[W-1], acc} + {{(W-7){add_val[7]}}, add_val};
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      acc <= '0;
    end else if (add_en) begin
      if (sum > SUM_MAX)      acc <= ACC_MAX;
      else if (sum < SUM_MIN) acc <= ACC_MIN;
      else                    acc <= sum[W-1:0];
    end else if (decay_en && (acc != '0)) begin
      acc <= acc[W-1] ? acc + ONE : acc - ONE;
    end
  end

endmodule

// File: rtl/hid_mc.sv
// HID bridge: decodes MCU byte frames into keyboard, mouse, joystick and DB9 state.
// Optional feature macro: HID_MC_ANALOG_EN stores the joystick analog axes.
module hid_mc
  import hid_pkg::*;
#(
  parameter int NUM_JOY   = 2,
  parameter int NUM_FKEYS = 6,
  parameter int MOUSE_W   = 8,
  parameter int DIV_W     = 15
) (
  input  logic                      clk,
  input  logic                      reset_n,
  hid_mc_if.slave                   bus,
  input  logic [5:0]                db9_port,
  output logic                      irq,
  input  logic                      iack,
  output logic [NUM_JOY*8-1:0]      joy_dig,
  output logic [NUM_JOY*8-1:0]      joy_ax,
  output logic [NUM_JOY*8-1:0]      joy_ay,
  output logic [NUM_JOY*8-1:0]      joy_extra,
  output logic [NUM_JOY-1:0]        joy_strobe,
  output logic [7:0]                numpad,
  output logic [NUM_FKEYS-1:0]      fkeys,
  output logic [NUM_FKEYS-1:0]      fkey_toggle,
  output logic [2:0]                mouse_btns,
  output logic signed [MOUSE_W-1:0] mouse_x,
  output logic signed [MOUSE_W-1:0] mouse_y,
  output logic                      mouse_strobe
);

  logic [7:0]           cmd;
  logic [3:0]           idx;
  logic                 in_frame;
  logic [7:0]           joy_chan;
  logic [5:0]           db9_meta, db9_sync, db9_prev;
  logic                 irq_enable;
  logic [DIV_W-1:0]     div;
  logic [NUM_FKEYS-1:0] fkeys_q;

  logic                 start_evt, byte_evt, decay, db9_change;
  logic                 mouse_add_x, mouse_add_y, joy_byte;
  key_evt_t             key;
  logic [NUM_FKEYS-1:0] fkey_hit;
  logic [7:0]           numpad_hit;

  always_comb begin
    start_evt   = bus.data_in_strobe && bus.data_in_start;
    // Bytes outside a frame (e.g. the tail of a frame cut by reset) are dropped.
    byte_evt    = bus.data_in_strobe && !bus.data_in_start && in_frame;
    decay       = !bus.data_in_strobe && (div == '1);
    db9_change  = db9_sync != db9_prev;
    mouse_add_x = byte_evt && (cmd == CMD_MOUSE) && (idx == 4'd1);
    mouse_add_y = byte_evt && (cmd == CMD_MOUSE) && (idx == 4'd2);
    joy_byte    = byte_evt && (cmd == CMD_JOY);
    key         = bus.data_in;
    numpad_hit  = numpad_onehot(key.usage);
    fkey_hit    = '0;
    for (int i = 0; i < NUM_FKEYS; i++) begin
      fkey_hit[i] = key.usage == (FKEY_BASE + 7'(i));
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      cmd          <= '0;
      idx          <= '0;
      in_frame     <= 1'b0;
      joy_chan     <= '0;
      db9_meta     <= '0;
      db9_sync     <= '0;
      db9_prev     <= '0;
      irq_enable   <= 1'b0;
      irq          <= 1'b0;
      div          <= '0;
      fkeys_q      <= '0;
      fkeys        <= '0;
      fkey_toggle  <= '0;
      numpad       <= '0;
      mouse_btns   <= '0;
      mouse_strobe <= 1'b0;
      joy_dig      <= '0;
      joy_extra    <= '0;
      joy_strobe   <= '0;
      bus.data_out <= '0;
    end else begin
      joy_strobe   <= '0;
      mouse_strobe <= 1'b0;
      fkeys_q      <= fkeys;
      fkey_toggle  <= fkey_toggle ^ (fkeys & ~fkeys_q);
      db9_meta     <= db9_port;
      db9_sync     <= db9_meta;
      db9_prev     <= db9_sync;
      if (!bus.data_in_strobe) div <= div + DIV_W'(1);

      // A change arms irq once; re-arming needs another DB9 command.
      if (irq_enable && db9_change) irq_enable <= 1'b0;
      if (iack)                               irq <= 1'b0;
      else if (irq_enable && db9_change)      irq <= 1'b1;

      if (start_evt) begin
        cmd      <= bus.data_in;
        idx      <= '0;
        in_frame <= 1'b1;
      end else if (byte_evt) begin
        if (idx != 4'hF) idx <= idx + 4'd1;
        case (cmd)
          CMD_STATUS: begin
            if (idx == 4'd0)      bus.data_out <= 8'h01;
            else if (idx == 4'd1) bus.data_out <= 8'(NUM_JOY);
            else                  bus.data_out <= 8'h00;
          end
          CMD_KBD: begin
            if (idx == 4'd0) begin
              if (key.is_release) begin
                fkeys  <= fkeys & ~fkey_hit;
                numpad <= numpad & ~numpad_hit;
              end else begin
                fkeys  <= fkeys | fkey_hit;
                numpad <= numpad | numpad_hit;
              end
            end
          end
          CMD_MOUSE: begin
            if (idx == 4'd0) mouse_btns   <= bus.data_in[2:0];
            if (idx == 4'd2) mouse_strobe <= 1'b1;
          end
          CMD_JOY: begin
            if (idx == 4'd0) joy_chan <= bus.data_in;
            for (int k = 0; k < NUM_JOY; k++) begin
              if (joy_chan == 8'(k)) begin
                if (idx == 4'd1) joy_dig[8*k +: 8] <= bus.data_in;
                if (idx == 4'd4) begin
                  joy_extra[8*k +: 8] <= bus.data_in;
                  joy_strobe[k]       <= 1'b1;
                end
              end
            end
          end
          CMD_DB9: begin
            bus.data_out <= {2'b00, db9_sync};
            if (idx == 4'd0) irq_enable <= 1'b1;
          end
          default: ;
        endcase
      end
    end
  end

`ifdef HID_MC_ANALOG_EN
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      joy_ax <= '0;
      joy_ay <= '0;
    end else if (joy_byte) begin
      for (int k = 0; k < NUM_JOY; k++) begin
        if (joy_chan == 8'(k)) begin
          if (idx == 4'd2) joy_ax[8*k +: 8] <= bus.data_in;
          if (idx == 4'd3) joy_ay[8*k +: 8] <= bus.data_in;
        end
      end
    end
  end
`else
  // Axis bytes still advance the index so strobe timing matches the analog build.
  logic unused_joy_byte;
  assign unused_joy_byte = joy_byte;
  assign joy_ax = '0;
  assign joy_ay = '0;
`endif

  hid_mouse_axis #(.W(MOUSE_W)) u_axis_x (
    .clk      (clk),
    .reset_n  (reset_n),
    .add_en   (mouse_add_x),
    .add_val  (bus.data_in),
    .decay_en (decay),
    .acc      (mouse_x)
  );

  hid_mouse_axis #(.W(MOUSE_W)) u_axis_y (
    .clk      (clk),
    .reset_n  (reset_n),
    .add_en   (mouse_add_y),
    .add_val  (bus.data_in),
    .decay_en (decay),
    .acc      (mouse_y)
  );

endmodule

// File: doc/hid_mc.md
HID_MC -- requirements
Module: hid_mc

Interface
REQ-001 Parameter NUM_JOY, default 2, number of joystick channels (1..4).
REQ-002 Parameter NUM_FKEYS, default 6, number of tracked function keys F1..Fn (1..8).
REQ-003 Parameter MOUSE_W, default 8, width of the signed mouse accumulators (8..12).
REQ-004 Parameter DIV_W, default 15, width of the mouse decay divider.
REQ-005 Port clk, input, 1, the only clock.
REQ-006 Port reset_n, input, 1, synchronous active-low reset.
REQ-007 Port data_in_strobe / data_in_start / data_in[7:0], input, MCU byte valid / first byte of frame / byte value.
REQ-008 Port data_out, output, 8, reply byte to the MCU.
REQ-009 Port db9_port, input, 6, local joystick lines; port irq, output, 1; port iack, input, 1.
REQ-010 Port joy_dig / joy_ax / joy_ay / joy_extra, output, NUM_JOY*8 each, per-channel data with channel k at bits [8k+7:8k].
REQ-011 Port joy_strobe, output, NUM_JOY, one-cycle per-channel update pulse.
REQ-012 Port numpad, output, 8; fkeys, output, NUM_FKEYS; fkey_toggle, output, NUM_FKEYS.
REQ-013 Port mouse_btns, output, 3; mouse_x / mouse_y, output, MOUSE_W, signed; mouse_strobe, output, 1.

Function
REQ-014 A byte with data_in_start SHALL latch command and clear byte index; each following byte SHALL advance the index, saturating at 15.
REQ-015 Cmd 0 SHALL reply 0x01 on index 0 and NUM_JOY on index 1.
REQ-016 Cmd 1 index 0 SHALL be the key event: bit7 = release, [6:0] = usage code.
REQ-017 Press of usage 0x3A+i (i<NUM_FKEYS) SHALL set fkeys[i]; release SHALL clear only fkeys[i]; other bits are unaffected.
REQ-018 Numpad usages 5E,5C,5A,60,62,63,44,4B SHALL map to numpad bits 0..7 with the same per-key press/release rule.
REQ-019 fkey_toggle[i] SHALL invert exactly one cycle after each 0->1 edge of fkeys[i].
REQ-020 Cmd 2 SHALL load mouse_btns from index 0 [2:0], add signed index-1 and index-2 bytes to x and y, and pulse mouse_strobe in the index-2 cycle.
REQ-021 Mouse additions SHALL sign-extend to MOUSE_W and saturate at +(2^(MOUSE_W-1)-1) and -2^(MOUSE_W-1).
REQ-022 The divider SHALL increment only in cycles with data_in_strobe low; on wrap to 0 each non-zero accumulator SHALL step one toward zero.
REQ-023 Cmd 3: index 0 = channel, 1 = digital, 2 = ax, 3 = ay, 4 = extra plus joy_strobe[channel] pulse; channel >= NUM_JOY SHALL be ignored, with no strobe.
REQ-024 db9_port SHALL be double-registered; cmd 4 SHALL reply {2'b00, synced db9} on every byte and set irq_enable at index 0.
REQ-025 With irq_enable set, a synced db9 change SHALL set irq and clear irq_enable; iack SHALL clear irq and take priority over a same-cycle set.

Reset
REQ-026 While reset_n is low at a clk edge: all outputs 0, accumulators 0, divider 0, index 0, command 0, irq_enable 0; reset mid-frame SHALL discard the frame.

Configuration
REQ-027 Macro HID_MC_ANALOG_EN defined: analog axes are stored per REQ-023.
REQ-028 Macro HID_MC_ANALOG_EN undefined: joy_ax / joy_ay are constant 0, index 2/3 bytes are consumed but not stored, and strobe timing is unchanged.

Structure
REQ-029 Package hid_pkg SHALL hold the command codes (CMD_STATUS=0, CMD_KBD=1, CMD_MOUSE=2, CMD_JOY=3, CMD_DB9=4), the F1 base usage 0x3A, and the numpad usage table.
REQ-030 Sub-module hid_mouse_axis (saturating add plus decay) SHALL be instantiated once per axis.

Verification
REQ-031 Frame 00,xx,xx -> data_out 0x01 then NUM_JOY (0x02 at default).
REQ-032 Frame 01,3A then 01,3B then 01,BA -> fkeys 000010 at the end, fkey_toggle[0] toggled once and fkey_toggle[1] toggled once.
REQ-033 MOUSE_W=8, frame 02,01,7F,7F twice -> mouse_x = mouse_y = 127 (saturated), mouse_btns = 1; then idle 2^DIV_W cycles -> 126.
REQ-034 Frame 03,01,5A,10,20,03 -> channel 1 = 5A/10/20/03 with one joy_strobe[1] pulse; frame 03,05,... -> no change and no strobe.
REQ-035 Frame 04,xx, then db9 change 3F->3E -> irq high 3 cycles later; iack in that same set cycle -> irq stays low; a second change before the next cmd 4 -> no irq.
REQ-036 reset_n low during byte 2 of a cmd 2 frame -> all outputs 0 on the next edge; a following 01,3C -> fkeys[2] = 1.
